hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised load-use and branch hazard unit for the pipelined MIPS32 core. It sits beside the ID stage and keeps a per-register countdown scoreboard of in-flight writers. Each ID instruction is checked against the scoreboard using the latency of its producer (ALU or load), the consumer type (EX-stage or ID-resolved branch) and whether forwarding is enabled. It asserts `stall` until every operand the instruction uses can be read from the register file or forwarded.

## Interface
- `REG_AW`, 5: register address width; the scoreboard has 2^REG_AW entries.
- `WB_DIST`, 2: cycles a producer spends after issue before its write is visible to ID reads (EX, MEM with a write-first register file).
- `ALU_LAT`, 1: cycles from EX entry until an ALU result is forwardable.
- `LOAD_LAT`, 2: cycles from EX entry until load data is forwardable.
- `BR_EXTRA`, 1: extra cycles early that an ID-resolved branch needs its operands.
- `STALL_CW`, 16: width of the stall performance counter.

Ports:
- `clk` in 1: clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `fwd_en` in 1: forwarding network enabled.
- `pipe_hold` in 1: whole-pipeline freeze (memory wait).
- `id_valid` in 1: ID holds a valid instruction.
- `id_rs` in REG_AW: source 1 address; always used.
- `id_rt` in REG_AW: source 2 address.
- `id_rt_used` in 1: source 2 is read (R-type, SW, branch).
- `id_is_branch` in 1: instruction resolves in ID (BEQ/BNE/BLEZ/BGTZ).
- `id_wr_en` in 1: instruction writes a register.
- `id_rd` in REG_AW: destination address.
- `id_is_load` in 1: instruction is a load.
- `id_flush` in 1: squash the ID instruction this cycle.
- `stall` out 1: hold IF/ID and inject a bubble into EX.
- `haz_rs` out 1: source 1 is causing the stall.
- `haz_rt` out 1: source 2 is causing the stall.
- `stall_count` out STALL_CW: saturating count of stall cycles.

## Operation
- Each entry holds `cnt`, which is clog2(WB_DIST+1) bits, and a `ld` flag. An entry with `cnt`==0 is idle.
- **Issue condition:** `issue` = `id_valid` & ~`stall` & ~`id_flush` & ~`pipe_hold` & `id_wr_en` & (`id_rd`!=0).
- **On issue:** `cnt[id_rd]` <= WB_DIST and `ld[id_rd]` <= `id_is_load`.
- **Decrement:** every cycle with ~`pipe_hold`, every nonzero entry not being issued decrements by 1. When `issue` targets an entry that is also decrementing, issue wins.
- **Hold:** when `pipe_hold`=1, all entries and `stall_count` hold their values.
- **Threshold per source s:**
  - fwd_en=0: thr = 0.
  - fwd_en=1: thr = WB_DIST + 1 − (ld[s] ? LOAD_LAT : ALU_LAT) − (id_is_branch ? BR_EXTRA : 0).
  - Arithmetic is signed, one bit wider than `cnt`. A negative thr means every nonzero `cnt` stalls.
- **Source hazard:** a source is hazardous when it is used, its address is nonzero, `cnt[s]`!=0 and `cnt[s]` > thr. Register 0 never hazards.
- **Outputs:**
  - `haz_rs` = source-1 hazard & `id_valid`.
  - `haz_rt` = source-2 hazard & `id_valid` & `id_rt_used`.
  - `stall` = (`haz_rs` | `haz_rt`) & ~`id_flush`.
- **`stall_count`:** increments on each cycle with `stall` & ~`pipe_hold`, and saturates at all-ones.
- **`id_flush`:** forces `stall`=0 and prevents issue. The scoreboard still decrements normally.
- **Reset:** asynchronous; clears all `cnt`, all `ld` and `stall_count` immediately, including mid-stall. After reset, `stall`, `haz_rs` and `haz_rt` are all 0.

## Timing
- `stall`, `haz_rs` and `haz_rt` are combinational from registered state plus the ID inputs. There are no internal flops on them.
- Scoreboard updates are visible the cycle after issue.
- Default stall lengths, counted from a producer issued at cycle n with the consumer in ID at n+1:

| Producer | Consumer | fwd_en | Stall cycles |
|---|---|---|---|
| ALU | ALU | 1 | 0 |
| load | ALU | 1 | 1 |
| ALU | branch | 1 | 1 |
| load | branch | 1 | 2 |
| any | any | 0 | 2 |

- A stall lasts until the threshold is met, with no timeout. `pipe_hold` extends it cycle for cycle.
- A back-to-back reissue to the same `rd` restarts that entry's countdown.

## Structure
- **Package `hazard_pkg`:**
  - `reg_addr_t`.
  - Branch opcode constants, used by the decoder to drive `id_is_branch`: BEQ 6'h4, BNE 6'h5, BLEZ 6'h6, BGTZ 6'h7.
  - A function computing thr from the parameters.
- **Sub-module `hazard_sb_entry`:** one counter plus its load flag, with issue, decrement and hold inputs. The top level instantiates one per register and holds the compare logic and the perf counter.

## Test plan
1. `lw $2` issued, then `add $3,$2,$4` with fwd_en=1: `stall`=1 for 1 cycle with `haz_rs`=1; `stall_count`=1.
2. `add $5,…` then `beq $5,$6`: 1 stall cycle. `lw $5` then `beq $6,$5`: 2 stall cycles with `haz_rt`=1.
3. `add $7` then `sw $8,0($7)` with fwd_en=0: 2 stall cycles. Repeat with `id_rt_used`=0 and a hazard only on rt: no stall.
4. Writes to $0, or a consumer reading $0 after a load to $0: `stall` never asserts.
5. `lw $9` issue, then `pipe_hold`=1 for 3 cycles with a consumer in ID: `stall` is held high and `stall_count` frozen. After release, exactly 1 counted stall cycle.
6. `rst_n` low mid-stall after `lw $10`: `stall`=0 immediately. After release, a consumer of $10 does not stall. Also drive `id_flush` with a hazard present: `stall`=0 and no issue occurs.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types, branch opcodes and the forwarding threshold helper for the
// load-use / branch hazard scoreboard.
package hazard_pkg;

  localparam int REG_AW_DEF = 5;

  typedef logic [REG_AW_DEF-1:0] reg_addr_t;

  // Primary opcodes of the branches that resolve in ID; the decoder uses
  // these to drive id_is_branch.
  localparam logic [5:0] OP_BEQ  = 6'h4;
  localparam logic [5:0] OP_BNE  = 6'h5;
  localparam logic [5:0] OP_BLEZ = 6'h6;
  localparam logic [5:0] OP_BGTZ = 6'h7;

  // Largest remaining countdown a source may have and still be satisfied
  // (by forwarding). Without forwarding the value must be in the register
  // file, so only an idle entry is acceptable. May go negative.
  function automatic int calc_thr(input logic fwd_en,
                                  input logic src_ld,
                                  input logic is_br,
                                  input int   wb_dist,
                                  input int   alu_lat,
                                  input int   load_lat,
                                  input int   br_extra);
    if (!fwd_en) return 0;
    return wb_dist + 1 - (src_ld ? load_lat : alu_lat) - (is_br ? br_extra : 0);
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: countdown of cycles until the in-flight write to
// this register is visible to ID, plus whether the writer is a load.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int WB_DIST = 2,
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic             is_load,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt,
  output logic             ld
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ld_d, ld_q;

  // Next state: a new issue restarts the countdown, otherwise count down to idle.
  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    if (!hold) begin
      if (issue) begin
        cnt_d = CNT_W'(WB_DIST);
        ld_d  = is_load;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

  assign cnt = cnt_q;
  assign ld  = ld_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use and branch hazard unit beside the ID stage. Keeps one countdown
// per register and stalls ID until every used source is readable or
// forwardable; counts stall cycles with saturation.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int WB_DIST  = 2,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int BR_EXTRA = 1,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fwd_en,
  input  logic                pipe_hold,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic                id_rt_used,
  input  logic                id_is_branch,
  input  logic                id_wr_en,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_is_load,
  input  logic                id_flush,
  output logic                stall,
  output logic                haz_rs,
  output logic                haz_rt,
  output logic [STALL_CW-1:0] stall_count
);

  localparam int NREG  = 1 << REG_AW;
  localparam int CNT_W = $clog2(WB_DIST + 1);
  localparam int THR_W = CNT_W + 1;

  function automatic logic [STALL_CW-1:0] sat_inc(input logic [STALL_CW-1:0] v);
    return (&v) ? v : v + STALL_CW'(1);
  endfunction

  logic [CNT_W-1:0]        cnt_arr [NREG];
  logic [NREG-1:0]         ld_vec;
  logic                    issue;
  logic [CNT_W-1:0]        cnt_rs, cnt_rt;
  logic signed [THR_W-1:0] thr_rs, thr_rt;
  logic                    src_haz_rs, src_haz_rt;
  logic [STALL_CW-1:0]     stall_count_d, stall_count_q;

  // A bubble, a squash, a freeze or a write to $0 never reaches the scoreboard.
  assign issue = id_valid & ~stall & ~id_flush & ~pipe_hold & id_wr_en & (id_rd != '0);

  for (genvar i = 0; i < NREG; i++) begin : g_entry
    hazard_sb_entry #(
      .WB_DIST (WB_DIST),
      .CNT_W   (CNT_W)
    ) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .issue   (issue && (id_rd == REG_AW'(i))),
      .is_load (id_is_load),
      .hold    (pipe_hold),
      .cnt     (cnt_arr[i]),
      .ld      (ld_vec[i])
    );
  end

  // Per-source compare of the remaining countdown against the forwarding threshold.
  always_comb begin
    cnt_rs = cnt_arr[id_rs];
    cnt_rt = cnt_arr[id_rt];
    thr_rs = THR_W'(calc_thr(fwd_en, ld_vec[id_rs], id_is_branch,
                             WB_DIST, ALU_LAT, LOAD_LAT, BR_EXTRA));
    thr_rt = THR_W'(calc_thr(fwd_en, ld_vec[id_rt], id_is_branch,
                             WB_DIST, ALU_LAT, LOAD_LAT, BR_EXTRA));
    src_haz_rs = (id_rs != '0) && (cnt_rs != '0) &&
                 ($signed({1'b0, cnt_rs}) > thr_rs);
    src_haz_rt = (id_rt != '0) && (cnt_rt != '0) &&
                 ($signed({1'b0, cnt_rt}) > thr_rt);
  end

  assign haz_rs = src_haz_rs & id_valid;
  assign haz_rt = src_haz_rt & id_valid & id_rt_used;
  assign stall  = (haz_rs | haz_rt) & ~id_flush;

  // Stall counter advances only on unfrozen stall cycles.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !pipe_hold) stall_count_d = sat_inc(stall_count_q);
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timestamp model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int REG_AW   = 5;
  localparam int WB_DIST  = 2;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;
  localparam int BR_EXTRA = 1;
  localparam int STALL_CW = 16;
  localparam int NREG     = 1 << REG_AW;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      fwd_en = 1'b1, pipe_hold = 1'b0, id_valid = 1'b0;
  reg_addr_t id_rs = '0, id_rt = '0, id_rd = '0;
  logic      id_rt_used = 1'b0, id_is_branch = 1'b0, id_wr_en = 1'b0;
  logic      id_is_load = 1'b0, id_flush = 1'b0;
  logic      stall, haz_rs, haz_rt;
  logic [STALL_CW-1:0] stall_count;

  int vectors = 0;
  int errors  = 0;

  hazard_scoreboard #(
    .REG_AW(REG_AW), .WB_DIST(WB_DIST), .ALU_LAT(ALU_LAT),
    .LOAD_LAT(LOAD_LAT), .BR_EXTRA(BR_EXTRA), .STALL_CW(STALL_CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en), .pipe_hold(pipe_hold),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_is_branch(id_is_branch), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_flush(id_flush),
    .stall(stall), .haz_rs(haz_rs), .haz_rt(haz_rt), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each register remembers the (unfrozen) cycle its latest writer issued;
  // the write becomes visible WB_DIST unfrozen cycles later.
  int   cyc;
  int   iss_cyc [NREG];
  logic iss_ld  [NREG];
  int   sc_m;

  function automatic int m_rem(input int r);
    int d;
    d = WB_DIST - (cyc - iss_cyc[r]);
    return (d < 0) ? 0 : d;
  endfunction

  function automatic logic m_src_haz(input int r, input logic used);
    int rem, need;
    rem = m_rem(r);
    if (!used || r == 0 || rem == 0) return 1'b0;
    need = fwd_en ? WB_DIST + 1 - (iss_ld[r] ? LOAD_LAT : ALU_LAT)
                    - (id_is_branch ? BR_EXTRA : 0) : 0;
    return rem > need;
  endfunction

  function automatic logic m_haz_rs();
    return id_valid && m_src_haz(int'(id_rs), 1'b1);
  endfunction
  function automatic logic m_haz_rt();
    return id_valid && m_src_haz(int'(id_rt), id_rt_used);
  endfunction
  function automatic logic m_stall();
    return (m_haz_rs() || m_haz_rt()) && !id_flush;
  endfunction
  function automatic logic m_issue();
    return id_valid && !m_stall() && !id_flush && id_wr_en && (id_rd != '0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= 0;
      sc_m <= 0;
      for (int r = 0; r < NREG; r++) begin
        iss_cyc[r] <= -1000;
        iss_ld[r]  <= 1'b0;
      end
    end else if (!pipe_hold) begin
      cyc <= cyc + 1;
      if (m_issue()) begin
        iss_cyc[id_rd] <= cyc + 1;
        iss_ld[id_rd]  <= id_is_load;
      end
      if (m_stall() && sc_m != (1 << STALL_CW) - 1) sc_m <= sc_m + 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_stall",  32'(stall),       32'(m_stall()));
    chk("model_haz_rs", 32'(haz_rs),      32'(m_haz_rs()));
    chk("model_haz_rt", 32'(haz_rt),      32'(m_haz_rt()));
    chk("model_count",  32'(stall_count), 32'(sc_m));
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic is_br_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rt = '0; id_rt_used = 0; id_is_branch = 0;
    id_wr_en = 0; id_rd = '0; id_is_load = 0; id_flush = 0; pipe_hold = 0;
  endtask

  task automatic instr(input logic [5:0] op, input int rs, input int rt,
                       input logic rt_used, input logic wr, input int rd,
                       input logic ld);
    id_valid = 1; id_rs = reg_addr_t'(rs); id_rt = reg_addr_t'(rt);
    id_rt_used = rt_used; id_is_branch = is_br_op(op); id_wr_en = wr;
    id_rd = reg_addr_t'(rd); id_is_load = ld; id_flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("reset_stall", 32'(stall), 0);
    chk("reset_count", 32'(stall_count), 0);
  endtask

  initial begin
    idle();
    tick();
    fwd_en = 1;
    do_reset();

    // 1: lw $2 ; add $3,$2,$4
    instr(6'h23, 0, 2, 0, 1, 2, 1); tick();
    instr(6'h00, 2, 4, 1, 1, 3, 0); #1;
    chk("t1_stall", 32'(stall), 1);
    chk("t1_haz_rs", 32'(haz_rs), 1);
    tick(); #1;
    chk("t1_release", 32'(stall), 0);
    chk("t1_count", 32'(stall_count), 1);
    tick(); idle();

    // 2a: add $5 ; beq $5,$6
    do_reset();
    instr(6'h00, 1, 1, 1, 1, 5, 0); tick();
    instr(OP_BEQ, 5, 6, 1, 0, 0, 0); #1;
    chk("t2a_stall", 32'(stall), 1);
    tick(); #1;
    chk("t2a_release", 32'(stall), 0);
    tick(); idle();

    // 2b: lw $5 ; beq $6,$5
    do_reset();
    instr(6'h23, 0, 5, 0, 1, 5, 1); tick();
    instr(OP_BEQ, 6, 5, 1, 0, 0, 0); #1;
    chk("t2b_stall1", 32'(stall), 1);
    chk("t2b_haz_rt", 32'(haz_rt), 1);
    tick(); #1;
    chk("t2b_stall2", 32'(stall), 1);
    tick(); #1;
    chk("t2b_release", 32'(stall), 0);
    chk("t2b_count", 32'(stall_count), 2);
    tick(); idle();

    // 3: no forwarding, add $7 ; sw $8,0($7)
    do_reset();
    fwd_en = 0;
    instr(6'h00, 1, 1, 1, 1, 7, 0); tick();
    instr(6'h2b, 7, 8, 1, 0, 0, 0); #1;
    chk("t3_stall1", 32'(stall), 1);
    tick(); #1;
    chk("t3_stall2", 32'(stall), 1);
    tick(); #1;
    chk("t3_release", 32'(stall), 0);
    tick();
    instr(6'h00, 1, 1, 1, 1, 7, 0); tick();
    instr(6'h08, 8, 7, 0, 1, 9, 0); #1;
    chk("t3_rt_unused", 32'(stall), 0);
    chk("t3_rt_unused_haz", 32'(haz_rt), 0);
    tick(); idle();
    fwd_en = 1;

    // 4: writes to $0 and reads of $0 never hazard
    do_reset();
    fwd_en = 0;
    instr(6'h23, 1, 0, 0, 1, 0, 1); tick();
    instr(6'h00, 0, 0, 1, 1, 3, 0); #1;
    chk("t4_zero", 32'(stall), 0);
    tick(); #1;
    chk("t4_zero2", 32'(stall), 0);
    idle(); fwd_en = 1;

    // 5: lw $9 then a consumer frozen by pipe_hold
    do_reset();
    instr(6'h23, 0, 9, 0, 1, 9, 1); tick();
    instr(6'h00, 9, 1, 1, 1, 4, 0);
    pipe_hold = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_hold_stall", 32'(stall), 1);
      chk("t5_hold_count", 32'(stall_count), 0);
      tick();
    end
    pipe_hold = 0; #1;
    chk("t5_after_hold", 32'(stall), 1);
    tick(); #1;
    chk("t5_release", 32'(stall), 0);
    chk("t5_count", 32'(stall_count), 1);
    tick(); idle();

    // 6: asynchronous reset mid-stall, then flush with a hazard present
    do_reset();
    instr(6'h23, 0, 10, 0, 1, 10, 1); tick();
    instr(6'h00, 10, 1, 1, 1, 4, 0); #1;
    chk("t6_pre_stall", 32'(stall), 1);
    #1 rst_n = 0;
    #1;
    chk("t6_rst_stall", 32'(stall), 0);
    chk("t6_rst_haz", 32'(haz_rs), 0);
    tick();
    rst_n = 1; #1;
    chk("t6_post_rst", 32'(stall), 0);
    tick();
    instr(6'h23, 0, 11, 0, 1, 11, 1); tick();
    instr(6'h00, 11, 1, 1, 1, 12, 0);
    id_flush = 1; #1;
    chk("t6_flush_stall", 32'(stall), 0);
    chk("t6_flush_haz", 32'(haz_rs), 1);
    tick();
    fwd_en = 0;
    instr(6'h00, 12, 0, 0, 0, 0, 0); #1;
    chk("t6_no_issue", 32'(stall), 0);
    tick(); idle(); fwd_en = 1;

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 4000; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0: op = OP_BEQ;
        1: op = OP_BNE;
        2: op = OP_BLEZ;
        3: op = OP_BGTZ;
        4: op = 6'h23;
        default: op = 6'h00;
      endcase
      id_valid     = ($urandom_range(0, 9) != 0);
      id_rs        = reg_addr_t'($urandom_range(0, 7));
      id_rt        = reg_addr_t'($urandom_range(0, 7));
      id_rt_used   = $urandom_range(0, 1);
      id_is_branch = is_br_op(op);
      id_wr_en     = !id_is_branch && ($urandom_range(0, 3) != 0);
      id_rd        = reg_addr_t'($urandom_range(0, 7));
      id_is_load   = (op == 6'h23);
      id_flush     = ($urandom_range(0, 15) == 0);
      pipe_hold    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) fwd_en = ~fwd_en;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 0;
        #2 rst_n = 1;
      end
      tick();
    end

    idle();
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
